// File: rtl/addsub16_seq_pkg.sv
// addsub16_seq_pkg: shared state type and default sizing for the slice-serial adder/subtractor
package addsub16_seq_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int SLICE_DEF = 4;
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
endpackage

// File: rtl/addsub16_seq_slice_add.sv
// slice_add: combinational N-bit adder with carry-in and carry-out
module slice_add #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
endmodule

// File: rtl/addsub16_seq.sv
// addsub16_seq: add/subtract processed SLICE bits per cycle, LSB slice first
module addsub16_seq
  import addsub16_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);
  localparam int NS = WIDTH / SLICE;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_x, r_y, r_s;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_cout, r_ovf, r_busy, r_done;
  logic [SLICE-1:0] w_a, w_b, w_sum;
  logic             w_co, w_last, w_go;
  assign w_a    = r_x[r_cnt*SLICE +: SLICE];
  assign w_b    = r_y[r_cnt*SLICE +: SLICE];
  assign w_last = r_cnt == CW'(NS - 1);
  // r_done blocks capture so a held start leaves one idle cycle after done
  assign w_go   = (r_state == IDLE) && start && !r_done;
  slice_add #(.N(SLICE)) u_slice (
    .a   (w_a),
    .b   (w_b),
    .cin (r_carry),
    .sum (w_sum),
    .cout(w_co)
  );
  always_comb begin
    w_next = (r_state == IDLE) ? (w_go ? RUN : IDLE) :
             (r_state == RUN)  ? (w_last ? FINISH : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_s     <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= r_state == FINISH;
      if (w_go) begin
        r_x     <= x;
        r_y     <= sub ? ~y : y;
        r_carry <= sub | cin;
        r_cnt   <= '0;
        r_busy  <= 1'b1;
      end else if (r_done) begin
        r_busy <= 1'b0;
      end
      if (r_state == RUN) begin
        r_s[r_cnt*SLICE +: SLICE] <= w_sum;
        r_carry                   <= w_co;
        r_cnt                     <= r_cnt + 1'b1;
        if (w_last) begin
          r_cout <= w_co;
          r_ovf  <= (r_x[WIDTH-1] == r_y[WIDTH-1]) && (w_sum[SLICE-1] != r_x[WIDTH-1]);
        end
      end
    end
  end
  assign s    = r_s;
  assign cout = r_cout;
  assign ovf  = r_ovf;
  assign busy = r_busy;
  assign done = r_done;
endmodule

// File: tb/tb_addsub16_seq.sv
// tb_addsub16_seq: directed vector table plus corner sequences for addsub16_seq
module tb_addsub16_seq;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [15:0] x = '0, y = '0, s;
  logic        cout, ovf, busy, done;
  int          n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  addsub16_seq #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin),
    .x(x), .y(y), .s(s), .cout(cout), .ovf(ovf), .busy(busy), .done(done)
  );
  typedef struct {
    logic        sub;
    logic        cin;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;
  vec_t v[10];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // issues one op; samples on falling edges, k counts cycles after the capture edge
  task automatic run_op(input logic op_sub, input logic op_cin, input logic [15:0] ox,
                        input logic [15:0] oy, input bit disturb,
                        output int t_done, output int pulses);
    @(negedge clk);
    sub = op_sub; cin = op_cin; x = ox; y = oy; start = 1'b1;
    t_done = -1;
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (t_done < 0) t_done = k;
      end
      if (k == 1) begin
        chk("busy_after_capture", 32'(busy), 32'd1);
        start = 1'b0;
      end
      if (disturb && k == 2) begin
        x = 16'hFFFF; y = 16'hFFFF; sub = 1'b1; cin = 1'b1; start = 1'b1;
      end
      if (disturb && k == 3) start = 1'b0;
    end
  endtask
  initial begin
    int td, np, seen;
    int dpos[$];
    v[0] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0};
    v[1] = '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    v[2] = '{1'b1, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    v[3] = '{1'b0, 1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0};
    v[4] = '{1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    v[5] = '{1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
    v[6] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};
    v[7] = '{1'b0, 1'b0, 16'hABCD, 16'h1234, 16'hBE01, 1'b0, 1'b0};
    v[8] = '{1'b1, 1'b0, 16'h1234, 16'hABCD, 16'h6667, 1'b0, 1'b0};
    v[9] = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
    repeat (3) @(negedge clk);
    chk("rst_s", 32'(s), 32'h0);
    chk("rst_cout", 32'(cout), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run_op(v[i].sub, v[i].cin, v[i].x, v[i].y, 1'b0, td, np);
      chk($sformatf("v%0d_latency", i), 32'(td), 32'd6);
      chk($sformatf("v%0d_pulses", i), 32'(np), 32'd1);
      chk($sformatf("v%0d_s", i), 32'(s), 32'(v[i].s));
      chk($sformatf("v%0d_cout", i), 32'(cout), 32'(v[i].cout));
      chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(v[i].ovf));
      chk($sformatf("v%0d_idle_busy", i), 32'(busy), 32'd0);
    end
    // operands and start disturbed while busy
    run_op(1'b0, 1'b0, 16'h1234, 16'h1111, 1'b1, td, np);
    chk("mid_latency", 32'(td), 32'd6);
    chk("mid_pulses", 32'(np), 32'd1);
    chk("mid_s", 32'(s), 32'h2345);
    chk("mid_cout", 32'(cout), 32'h0);
    chk("mid_ovf", 32'(ovf), 32'h0);
    // reset while the third slice is being processed
    run_op(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, td, np);
    @(negedge clk);
    sub = 1'b0; cin = 1'b0; x = 16'h00FF; y = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_s", 32'(s), 32'h0);
    chk("abort_cout", 32'(cout), 32'h0);
    chk("abort_ovf", 32'(ovf), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    run_op(1'b1, 1'b0, 16'h8000, 16'h0001, 1'b0, td, np);
    chk("post_rst_latency", 32'(td), 32'd6);
    chk("post_rst_s", 32'(s), 32'h7FFF);
    chk("post_rst_cout", 32'(cout), 32'h1);
    chk("post_rst_ovf", 32'(ovf), 32'h1);
    // start held high for three back-to-back operations
    @(negedge clk);
    sub = 1'b0; cin = 1'b0; x = 16'h0010; y = 16'h0001; start = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (dpos.size() > 0 && dpos[$] == k - 1) chk($sformatf("b2b_idle%0d", dpos.size()), 32'(busy), 32'd0);
      if (done) begin
        dpos.push_back(k);
        chk($sformatf("b2b_s%0d", dpos.size()), 32'(s), 32'(16'h0001 + 16'h0010 * dpos.size()));
        x = x + 16'h0010;
        if (dpos.size() == 3) start = 1'b0;
      end
    end
    chk("b2b_pulses", 32'(dpos.size()), 32'd3);
    if (dpos.size() == 3) begin
      chk("b2b_t1", 32'(dpos[0]), 32'd6);
      chk("b2b_t2", 32'(dpos[1]), 32'd13);
      chk("b2b_t3", 32'(dpos[2]), 32'd20);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/addsub16_seq.md
ADDSUB16_SEQ -- requirements
Module: addsub16_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand and result width in bits.
REQ-002 The block SHALL have parameter SLICE, default 4, bits processed per cycle; WIDTH SHALL be a multiple of SLICE.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, request to begin an operation.
REQ-006 The block SHALL have port sub, input, 1, operation select: 0 = add, 1 = subtract.
REQ-007 The block SHALL have port cin, input, 1, carry-in; used only when sub=0.
REQ-008 The block SHALL have ports x and y, each input, WIDTH, the operands.
REQ-009 The block SHALL have port s, output, WIDTH, the registered result.
REQ-010 The block SHALL have port cout, output, 1, carry-out of the MSB; for sub=1, 1 means no borrow.
REQ-011 The block SHALL have port ovf, output, 1, signed two's-complement overflow.
REQ-012 The block SHALL have port busy, output, 1, high while an operation is in progress.
REQ-013 The block SHALL have port done, output, 1, one-cycle pulse when s, cout and ovf are valid.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, FINISH.
REQ-015 In IDLE with start=1, the block SHALL capture x, ~y (sub=1) or y (sub=0), and carry = sub ? 1 : cin, clear the slice counter, and go to RUN.
REQ-016 In RUN, each cycle SHALL add one SLICE-bit slice of the captured operands (LSB slice first) plus the stored carry, write the slice sum into s, store the slice carry, and increment the counter.
REQ-017 After the final slice, RUN SHALL go to FINISH; FINISH SHALL assert done for one cycle and return to IDLE.
REQ-018 With WIDTH=16 and SLICE=4, done SHALL be high exactly 6 cycles after the edge at which start was sampled (1 capture, 4 slices, 1 finish), and busy SHALL be high from the cycle after capture until done, inclusive.
REQ-019 The final result SHALL be s = x + y + cin (sub=0) or x - y (sub=1), modulo 2^WIDTH.
REQ-020 ovf SHALL equal (x_eff[MSB] == y_eff[MSB]) && (s[MSB] != x_eff[MSB]), where x_eff and y_eff are the operands actually added.
REQ-021 start, sub, cin, x and y SHALL be ignored outside IDLE, and changing them mid-operation SHALL NOT affect the result.
REQ-022 s, cout and ovf SHALL hold their last values from done until the next capture; intermediate slice values on s are don't-care while busy=1.
REQ-023 start held high continuously SHALL start back-to-back operations, with one IDLE cycle between done and the next capture.

Reset
REQ-024 When rst_n=0 at a clock edge, the block SHALL enter IDLE and clear s=0, cout=0, ovf=0, busy=0, done=0 and the counter and stored carry to 0.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after release SHALL behave as the first operation after power-up.

Structure
REQ-026 A shared package SHALL hold the state enumeration type and the default WIDTH and SLICE constants.
REQ-027 One combinational sub-module, slice_add, SHALL compute a SLICE-bit sum and carry-out from a, b and cin, and SHALL be instantiated once.

Verification
REQ-028 Add: x=0xFFFF, y=0x0000, cin=1, sub=0 -> s=0x0000, cout=1, ovf=0, done 6 cycles after start.
REQ-029 Signed overflow: x=0x7FFF, y=0x0001, cin=0, sub=0 -> s=0x8000, cout=0, ovf=1.
REQ-030 Subtract with borrow: x=0x0005, y=0x0007, sub=1, cin=1 -> s=0xFFFE, cout=0, ovf=0 (cin ignored).
REQ-031 Operands changed mid-run: start with x=0x1234, y=0x1111, sub=0, cin=0, then drive x=y=0xFFFF while busy=1 -> s=0x2345, and a start pulse during busy is ignored.
REQ-032 Reset mid-run: assert rst_n=0 during the third slice -> all outputs 0 and no done pulse; the next op x=0x8000, y=0x0001, sub=1 -> s=0x7FFF, cout=1, ovf=1.
REQ-033 Back-to-back: start held high for 3 operations -> exactly 3 done pulses, each followed by one IDLE cycle, with the correct result for each.
